// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Register window (word offsets): 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          empty, full, overflow;
  logic [15:0]   div, cur_div, baud;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          pop, push, bit_end, tx_nxt;
  logic [1:0]    offset;
  logic          wr_txdata, wr_status, wr_div;

  assign sel     = (bus_address[31:4] == BASE_ADDR[31:4]);
  assign offset  = bus_address[3:2];

  assign wr_txdata = sel & bus_write & (offset == 2'd0);
  assign wr_status = sel & bus_write & (offset == 2'd1);
  assign wr_div    = sel & bus_write & (offset == 2'd2);

  // Extra pointer bit distinguishes full from empty; count wraps naturally.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(FIFO_DEPTH));
  // A pop only happens on a non-empty FIFO, so a full FIFO can accept a push
  // in the same cycle it pops.
  assign push    = wr_txdata & (~full | pop);
  assign bit_end = (state != IDLE) && (baud == 16'd0);

  // Combinational load data; zero when not addressed so it can be ORed with ram.
  always_comb begin
    bus_read_data = 32'h0;
    if (sel && bus_read) begin
      case (offset)
        2'd1:    bus_read_data = {16'h0, {(8-PW){1'b0}}, count, 4'h0,
                                  overflow, empty, full, (state != IDLE)};
        2'd2:    bus_read_data = {16'h0, div};
        default: bus_read_data = 32'h0;
      endcase
    end
  end

  // FIFO storage, pointers, sticky overflow and divisor register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus_write_data[7:0];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_txdata && full && !pop) overflow <= 1'b1;
      else if (wr_status)            overflow <= 1'b0;
      // A zero divisor would never end a bit; treat it as one clock per bit.
      if (wr_div) div <= (bus_write_data[15:0] == 16'd0) ? 16'd1 : bus_write_data[15:0];
    end
  end

  // Serializer state register and registered line output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
    end
  end

  // Next state, FIFO pop and next line level.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = tx;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = START;
        tx_nxt    = 1'b0;
      end
      START: if (bit_end) begin
        state_nxt = DATA;
        tx_nxt    = shift[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt == 3'd7) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end else begin
          tx_nxt    = shift[1];
        end
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and baud counter; divisor frozen per frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift   <= 8'h0;
      bit_cnt <= 3'd0;
      baud    <= 16'd0;
      cur_div <= DEFAULT_DIV;
    end else if (pop) begin
      shift   <= mem[rd_ptr[AW-1:0]];
      cur_div <= div;
      bit_cnt <= 3'd0;
      baud    <= div - 16'd1;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baud <= cur_div - 16'd1;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud <= baud - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: a tx-line monitor decodes frames and
// compares them against a queue of expected bytes pushed as writes are issued.
module tb_bus_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_address = 32'h0;
  logic [31:0] bus_write_data = 32'h0;
  logic [31:0] bus_read_data;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic        sel;
  logic        tx;

  localparam logic [31:0] A_TX = 32'h1000, A_ST = 32'h1004, A_DIV = 32'h1008, A_RSV = 32'h100C;

  bus_uart_tx dut (
    .clock(clock), .reset(reset), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_write(bus_write), .bus_read(bus_read), .sel(sel), .tx(tx)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] d; int div; bit b2b; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int negc = 0;
  int last_end = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus_address = a; bus_write_data = d; bus_write = 1'b1;
    @(posedge clock);
    #1 bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    bus_address = a; bus_read = 1'b1;
    #1 d = bus_read_data;
    bus_read = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] d;
    for (int i = 0; i < budget; i++) begin
      bus_rd(A_ST, d);
      if (!d[0] && d[2]) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Frame monitor: samples tx every clock; one check per frame for content,
  // stability within each bit, and absence of a gap on back-to-back frames.
  initial begin : monitor
    exp_t e;
    logic [9:0] bits;
    int glitch;
    forever begin
      @(negedge clock);
      negc++;
      if (mon_en && tx === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.b2b) chk("b2b_gap", negc, last_end + 1);
          glitch = 0;
          bits = '0;
          for (int i = 0; i < 10; i++)
            for (int j = 0; j < e.div; j++) begin
              if (i != 0 || j != 0) begin
                @(negedge clock);
                negc++;
              end
              if (j == 0) bits[i] = tx;
              else if (tx !== bits[i]) glitch++;
            end
          last_end = negc;
          chk("frame", {22'h0, bits}, {22'h0, 1'b1, e.d, 1'b0});
          chk("bit_stable", glitch, 0);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    int n;
    exp_t e;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // reset state and decode
    bus_rd(A_ST, d);  chk("rst_status", d, 32'h4);
    bus_rd(A_DIV, d); chk("rst_div", d, 32'h4);
    chk("rst_tx", tx, 1);
    bus_rd(A_RSV, d); chk("rsv_read", d, 32'h0);
    @(negedge clock);
    bus_address = 32'h0000_0010; bus_read = 1'b1;
    #1 chk("sel_off", sel, 0);
    chk("rdata_off", bus_read_data, 32'h0);
    bus_read = 1'b0;
    bus_address = A_ST;
    #1 chk("rdata_noread", bus_read_data, 32'h0);

    // single frame 0xA5, div 4
    e = '{8'hA5, 4, 1'b0}; sb.push_back(e);
    bus_wr(A_TX, 32'hA5);
    bus_rd(A_ST, d); chk("tx_pre", tx, 1); chk("busy_pre", d[0], 0);
    bus_rd(A_ST, d); chk("tx_start", tx, 0);
    n = 0;
    while (d[0] && n < 200) begin
      n++;
      bus_rd(A_ST, d);
    end
    chk("busy_cycles", n, 40);
    chk("status_after", d, 32'h4);

    // six back-to-back writes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      e = '{8'(i * 8'h11), 4, (i != 1)}; sb.push_back(e);
    end
    for (int i = 1; i <= 6; i++) bus_wr(A_TX, 32'(i * 32'h11));
    bus_rd(A_ST, d); chk("status_ovf", d, 32'h0000_040B);
    wait_idle(1000);
    chk("sb_drained", sb.size(), 0);
    bus_rd(A_ST, d); chk("ovf_sticky", d[3], 1);
    bus_wr(A_ST, 32'h0);
    bus_rd(A_ST, d); chk("ovf_clear", d, 32'h4);

    // zero divisor stored as 1, 10-clock frame
    bus_wr(A_DIV, 32'h0);
    bus_rd(A_DIV, d); chk("div_zero", d, 32'h1);
    e = '{8'h00, 1, 1'b0}; sb.push_back(e);
    bus_wr(A_TX, 32'h00);
    wait_idle(200);
    chk("sb_div1", sb.size(), 0);

    // divisor change mid-frame only affects the next frame
    bus_wr(A_DIV, 32'h4);
    e = '{8'h3C, 4, 1'b0}; sb.push_back(e);
    e = '{8'hC3, 8, 1'b1}; sb.push_back(e);
    bus_wr(A_TX, 32'h3C);
    bus_wr(A_TX, 32'hC3);
    repeat (9) @(negedge clock);
    bus_wr(A_DIV, 32'h8);
    wait_idle(1000);
    chk("sb_divchg", sb.size(), 0);
    bus_rd(A_DIV, d); chk("div_8", d, 32'h8);

    // reset during data bit 3 aborts the frame
    bus_wr(A_DIV, 32'h6);
    mon_en = 1'b0;
    bus_wr(A_TX, 32'h5A);
    repeat (27) @(negedge clock);
    bus_rd(A_ST, d); chk("busy_before_rst", d[0], 1);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("rst_mid_tx", tx, 1);
    reset = 1'b0;
    bus_rd(A_ST, d);  chk("rst_mid_status", d, 32'h4);
    bus_rd(A_DIV, d); chk("rst_mid_div", d, 32'h4);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) n++;
    end
    chk("no_frame_after_rst", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
